// File: rtl/me_stage.sv
// Memory-access stage of the five-stage RISC-V pipeline: ready/valid data-RAM access,
// load extension, control-transfer redirect and the ME/WB pipeline register.
module me_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        me_write_reg_enable,
    input  logic        me_wb_aluOut_or_memOut,
    input  logic [1:0]  me_write_ram_flag,
    input  logic [2:0]  me_read_ram_flag,
    input  logic [1:0]  me_pc_condition,
    input  logic        me_branch_enable,
    input  logic [31:0] me_pc_add_imm_32,
    input  logic [31:0] me_rs1_data_add_imm_32_for_pc,
    input  logic [31:0] me_alu_out,
    input  logic [31:0] me_rs2_data,
    input  logic [4:0]  me_rd_addr,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic        ram_ready,
    input  logic [31:0] ram_rdata,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        misalign,
    output logic        bus_error,
    output logic        wb_write_reg_enable,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state, next_state;
    logic [CW-1:0]  cnt;
    logic           is_store, is_load, access, bad_align, timeout_fire;
    logic [1:0]     size;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    load_ext;
    logic           taken;
    logic [31:0]    target, redirect_pc_q;

    // Access decode; the store wins when both flags are set.
    always_comb begin
        is_store = (me_write_ram_flag != 2'd0);
        is_load  = (me_read_ram_flag >= 3'd1) && (me_read_ram_flag <= 3'd5);
        size     = 2'd0;
        if (is_store) begin
            size = me_write_ram_flag;
        end else begin
            case (me_read_ram_flag)
                3'd1, 3'd4: size = 2'd1;
                3'd2, 3'd5: size = 2'd2;
                3'd3:       size = 2'd3;
                default:    size = 2'd0;
            endcase
        end
        bad_align = ((size == 2'd2) && me_alu_out[0]) ||
                    ((size == 2'd3) && (me_alu_out[1:0] != 2'b00));
        access    = ~rst & (is_store | is_load);
    end

    // The counter includes the IDLE request cycle, so the access gets TIMEOUT_CYCLES
    // cycles in total and stall lasts TIMEOUT_CYCLES-1 of them before the abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state == WAIT)
                cnt <= (state == WAIT) ? cnt + 1'b1 : CW'(1);
            else
                cnt <= '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (ram_req && !ram_ready) next_state = WAIT;
            WAIT: if (ram_ready || timeout_fire || !ram_req) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ram_req      = access & ~bad_align;
        misalign     = access & bad_align;
        timeout_fire = ram_req && (state == WAIT) &&
                       (cnt == CW'(TIMEOUT_CYCLES - 1)) && !ram_ready;
        bus_error    = timeout_fire;
        stall        = ram_req & ~ram_ready & ~timeout_fire;
        ram_we       = ram_req & is_store;
        ram_addr     = rst ? 32'd0 : {me_alu_out[31:2], 2'b00};
        ram_be       = 4'b0000;
        ram_wdata    = 32'd0;
        if (ram_req) begin
            case (size)
                2'd1:    ram_be = 4'b0001 << me_alu_out[1:0];
                2'd2:    ram_be = 4'b0011 << me_alu_out[1:0];
                2'd3:    ram_be = 4'b1111;
                default: ram_be = 4'b0000;
            endcase
        end
        if (ram_req && is_store) begin
            case (me_write_ram_flag)
                2'd1:    ram_wdata = {4{me_rs2_data[7:0]}};
                2'd2:    ram_wdata = {2{me_rs2_data[15:0]}};
                default: ram_wdata = me_rs2_data;
            endcase
        end
    end

    // Lane selection and sign/zero extension of the returned word.
    always_comb begin
        case (me_alu_out[1:0])
            2'd0:    ld_byte = ram_rdata[7:0];
            2'd1:    ld_byte = ram_rdata[15:8];
            2'd2:    ld_byte = ram_rdata[23:16];
            default: ld_byte = ram_rdata[31:24];
        endcase
        ld_half = me_alu_out[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (me_read_ram_flag)
            3'd1:    load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    load_ext = {{16{ld_half[15]}}, ld_half};
            3'd4:    load_ext = {24'd0, ld_byte};
            3'd5:    load_ext = {16'd0, ld_half};
            default: load_ext = ram_rdata;
        endcase
    end

    // ME/WB register; a stalled cycle pushes a bubble instead of holding the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_write_reg_enable <= 1'b0;
            wb_rd_addr          <= 5'd0;
            wb_data             <= 32'd0;
        end else if (!stall) begin
            wb_write_reg_enable <= me_write_reg_enable & ~is_store & ~misalign & ~timeout_fire;
            wb_rd_addr          <= me_rd_addr;
            wb_data             <= me_wb_aluOut_or_memOut ? load_ext : me_alu_out;
        end else begin
            wb_write_reg_enable <= 1'b0;
        end
    end

    always_comb begin
        taken          = ((me_pc_condition == 2'd1) && me_branch_enable) ||
                         (me_pc_condition == 2'd2) || (me_pc_condition == 2'd3);
        target         = (me_pc_condition == 2'd3) ?
                         (me_rs1_data_add_imm_32_for_pc & ~32'd1) : me_pc_add_imm_32;
        redirect_valid = ~rst & ~stall & taken;
        redirect_pc    = redirect_valid ? target : redirect_pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            redirect_pc_q <= 32'd0;
        else if (redirect_valid)
            redirect_pc_q <= target;
    end

endmodule

// File: tb/tb_me_stage.sv
// Randomized self-checking bench for me_stage against a transaction-level model.
module tb_me_stage;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        me_write_reg_enable, me_wb_aluOut_or_memOut, me_branch_enable;
    logic [1:0]  me_write_ram_flag, me_pc_condition;
    logic [2:0]  me_read_ram_flag;
    logic [31:0] me_pc_add_imm_32, me_rs1_data_add_imm_32_for_pc, me_alu_out, me_rs2_data;
    logic [4:0]  me_rd_addr;
    logic        ram_req, ram_we, ram_ready;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic        stall, redirect_valid, misalign, bus_error, wb_write_reg_enable;
    logic [31:0] redirect_pc, wb_data;
    logic [4:0]  wb_rd_addr;

    int checks = 0;
    int passes = 0;
    logic [31:0] lastPc = 32'd0;

    me_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .me_write_reg_enable(me_write_reg_enable),
        .me_wb_aluOut_or_memOut(me_wb_aluOut_or_memOut),
        .me_write_ram_flag(me_write_ram_flag),
        .me_read_ram_flag(me_read_ram_flag),
        .me_pc_condition(me_pc_condition),
        .me_branch_enable(me_branch_enable),
        .me_pc_add_imm_32(me_pc_add_imm_32),
        .me_rs1_data_add_imm_32_for_pc(me_rs1_data_add_imm_32_for_pc),
        .me_alu_out(me_alu_out), .me_rs2_data(me_rs2_data), .me_rd_addr(me_rd_addr),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_ready(ram_ready), .ram_rdata(ram_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign(misalign), .bus_error(bus_error),
        .wb_write_reg_enable(wb_write_reg_enable), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        else
            passes++;
    endtask

    task automatic clearInputs();
        me_write_reg_enable = 0; me_wb_aluOut_or_memOut = 0; me_branch_enable = 0;
        me_write_ram_flag = 0; me_read_ram_flag = 0; me_pc_condition = 0;
        me_pc_add_imm_32 = 0; me_rs1_data_add_imm_32_for_pc = 0; me_alu_out = 0;
        me_rs2_data = 0; me_rd_addr = 0; ram_ready = 0; ram_rdata = 0;
    endtask

    // One instruction through ME, starting and ending on a falling edge.
    // waits = cycle index at which ram_ready rises, -1 for never.
    task automatic applyStimulus(input logic [1:0] wflag, input logic [2:0] rflag,
                                 input logic sel, input logic wen, input logic [1:0] cond,
                                 input logic br, input logic [31:0] pcimm, input logic [31:0] rs1imm,
                                 input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] rdata, input int waits);
        bit isStore, isLoad, access, mis, tmo, expWe, expRv, done, constAddr, firstSeen;
        int sz, off, expStall, stallCnt, reqCnt, misCnt, berrCnt, rvStall, cyc;
        logic [31:0] b, h, loadVal, expData, expPc, expBe, expWd, firstBe, firstWd, rvSeen, pcSeen;
        logic firstWe;
        isStore = (wflag != 0);
        isLoad  = (rflag >= 1 && rflag <= 5);
        access  = isStore || isLoad;
        if (isStore) sz = int'(wflag);
        else if (rflag == 1 || rflag == 4) sz = 1;
        else if (rflag == 2 || rflag == 5) sz = 2;
        else if (rflag == 3) sz = 3;
        else sz = 0;
        off = int'(alu % 4);
        mis = access && ((sz == 2 && off % 2 == 1) || (sz == 3 && off != 0));
        tmo = access && !mis && (waits < 0 || waits >= T);
        expStall = (!access || mis) ? 0 : (tmo ? T - 1 : waits);
        expWe = wen && !isStore && !mis && !tmo;
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (rflag)
            1: loadVal = (b >= 128) ? (b | 32'hFFFFFF00) : b;
            2: loadVal = (h >= 32768) ? (h | 32'hFFFF0000) : h;
            4: loadVal = b;
            5: loadVal = h;
            default: loadVal = rdata;
        endcase
        expData = sel ? loadVal : alu;
        expBe = (sz == 1) ? (32'd1 << off) : (sz == 2) ? (32'd3 << off) : 32'hF;
        expWd = (wflag == 1) ? (rs2 & 32'hFF) * 32'h01010101 :
                (wflag == 2) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
        expRv = (cond == 1 && br) || cond == 2 || cond == 3;
        expPc = !expRv ? lastPc : (cond == 3 ? rs1imm - (rs1imm % 2) : pcimm);
        lastPc = expPc;

        me_write_ram_flag = wflag; me_read_ram_flag = rflag; me_wb_aluOut_or_memOut = sel;
        me_write_reg_enable = wen; me_pc_condition = cond; me_branch_enable = br;
        me_pc_add_imm_32 = pcimm; me_rs1_data_add_imm_32_for_pc = rs1imm;
        me_alu_out = alu; me_rs2_data = rs2; me_rd_addr = rd; ram_rdata = rdata;
        ram_ready = (waits == 0);
        stallCnt = 0; reqCnt = 0; misCnt = 0; berrCnt = 0; rvStall = 0; cyc = 0;
        done = 0; constAddr = 1; firstSeen = 0;
        firstBe = 0; firstWd = 0; firstWe = 0; rvSeen = 0; pcSeen = 0;
        while (!done && cyc < 60) begin
            #2;
            if (ram_req) begin
                reqCnt++;
                if (ram_addr !== {alu[31:2], 2'b00}) constAddr = 0;
                if (!firstSeen) begin
                    firstSeen = 1; firstBe = {28'd0, ram_be}; firstWd = ram_wdata; firstWe = ram_we;
                end
            end
            if (misalign) misCnt++;
            if (bus_error) berrCnt++;
            if (stall) begin
                stallCnt++;
                if (redirect_valid) rvStall++;
            end else begin
                done = 1;
                rvSeen = {31'd0, redirect_valid};
                pcSeen = redirect_pc;
            end
            @(negedge clk);
            cyc++;
            ram_ready = (waits >= 0 && cyc == waits);
        end
        ram_ready = 0;
        checkOutput("terminated", {31'd0, done}, 32'd1);
        checkOutput("stall_cycles", stallCnt, expStall);
        checkOutput("req_cycles", reqCnt, (access && !mis) ? expStall + 1 : 0);
        checkOutput("misalign", misCnt, mis ? 1 : 0);
        checkOutput("bus_error", berrCnt, tmo ? 1 : 0);
        checkOutput("wb_we", {31'd0, wb_write_reg_enable}, {31'd0, expWe});
        if (expWe) begin
            checkOutput("wb_rd", {27'd0, wb_rd_addr}, {27'd0, rd});
            checkOutput("wb_data", wb_data, expData);
        end
        if (access && !mis) begin
            checkOutput("addr_const", {31'd0, constAddr}, 32'd1);
            checkOutput("ram_we", {31'd0, firstWe}, {31'd0, isStore});
            checkOutput("ram_be", firstBe, isStore ? expBe : firstBe & expBe);
            if (isStore) checkOutput("ram_wdata", firstWd, expWd);
        end
        checkOutput("redir_in_stall", rvStall, 0);
        checkOutput("redirect_valid", rvSeen, {31'd0, expRv});
        checkOutput("redirect_pc", pcSeen, expPc);
    endtask

    initial begin
        logic [1:0] wf;
        logic [2:0] rf;
        logic [31:0] a;
        int w;
        clearInputs();
        rst = 1;
        @(negedge clk); @(negedge clk);
        #1;
        checkOutput("rst_req", {31'd0, ram_req}, 0);
        checkOutput("rst_stall", {31'd0, stall}, 0);
        checkOutput("rst_wb_we", {31'd0, wb_write_reg_enable}, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_wb_rd", {27'd0, wb_rd_addr}, 0);
        checkOutput("rst_redirect_pc", redirect_pc, 0);
        @(negedge clk);
        rst = 0;

        $display("[TB] directed cases");
        applyStimulus(0, 3, 1, 1, 0, 0, 0, 0, 32'h100, 0, 5'd3, 32'hDEADBEEF, 0);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 32'h103, 0, 5'd4, 32'h80FFFFFF, 3);
        applyStimulus(0, 4, 1, 1, 0, 0, 0, 0, 32'h103, 0, 5'd5, 32'h80FFFFFF, 3);
        applyStimulus(2, 0, 0, 1, 0, 0, 0, 0, 32'h102, 32'h1234ABCD, 5'd6, 0, 0);
        applyStimulus(0, 3, 1, 1, 0, 0, 0, 0, 32'h101, 0, 5'd7, 32'h11111111, 0);
        applyStimulus(0, 3, 1, 1, 0, 0, 0, 0, 32'h200, 0, 5'd8, 32'h0, -1);
        applyStimulus(0, 2, 1, 1, 0, 0, 0, 0, 32'h202, 0, 5'd9, 32'h8001FFFF, T - 1);
        applyStimulus(0, 0, 0, 1, 3, 0, 32'h4000, 32'h2001, 32'h55, 0, 5'd1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h3000, 0, 32'h66, 0, 5'd0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h3000, 0, 32'h66, 0, 5'd0, 0, 0);

        $display("[TB] reset during WAIT");
        me_read_ram_flag = 3; me_write_reg_enable = 1; me_wb_aluOut_or_memOut = 1;
        me_alu_out = 32'h300; me_rd_addr = 5'd2; ram_ready = 0;
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1;
        checkOutput("rstw_req", {31'd0, ram_req}, 0);
        checkOutput("rstw_stall", {31'd0, stall}, 0);
        checkOutput("rstw_addr", ram_addr, 0);
        checkOutput("rstw_wb_we", {31'd0, wb_write_reg_enable}, 0);
        checkOutput("rstw_wb_data", wb_data, 0);
        checkOutput("rstw_redirect_pc", redirect_pc, 0);
        clearInputs();
        @(negedge clk);
        rst = 0;
        lastPc = 0;
        applyStimulus(0, 3, 1, 1, 0, 0, 0, 0, 32'h400, 0, 5'd10, 32'hCAFEF00D, 0);

        $display("[TB] random cases");
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            w = ($urandom_range(0, 9) == 0) ? -1 : ($urandom_range(0, 9) == 0 ? T - 1 : $urandom_range(0, 4));
            case ($urandom_range(0, 2))
                0: begin
                    rf = 3'($urandom_range(1, 5));
                    applyStimulus(0, rf, 1'($urandom), 1'($urandom), 0, 0, 0, 0, a, 0,
                                  5'($urandom), $urandom, w);
                end
                1: begin
                    wf = 2'($urandom_range(1, 3));
                    applyStimulus(wf, 3'($urandom), 0, 1'($urandom), 0, 0, 0, 0, a, $urandom,
                                  5'($urandom), $urandom, w);
                end
                default: begin
                    rf = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(6, 7));
                    applyStimulus(0, rf, 0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom,
                                  $urandom, a, 0, 5'($urandom), $urandom, 0);
                end
            endcase
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/me_stage.md
# me_stage

Memory-access stage of the five-stage RISC-V pipeline, sitting between the EX/ME pipeline register and writeback. It performs loads and stores through a ready/valid data-RAM port with wait states, sign/zero-extends load data and resolves the control-transfer redirect. It also contains the ME/WB register that feeds the register file. While a RAM access is outstanding it raises `stall` so upstream holds its inputs.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles to wait for `ram_ready` before the access is aborted.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `me_write_reg_enable` in 1: the instruction writes rd.
- `me_wb_aluOut_or_memOut` in 1: writeback source; 0 selects ALU, 1 selects memory.
- `me_write_ram_flag` in 2: store size; 0 none, 1 SB, 2 SH, 3 SW.
- `me_read_ram_flag` in 3: load type; 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 are treated as none.
- `me_pc_condition` in 2: control transfer; 0 sequential, 1 conditional branch, 2 JAL, 3 JALR.
- `me_branch_enable` in 1: the branch condition evaluated true.
- `me_pc_add_imm_32` in 32: target for branch and JAL.
- `me_rs1_data_add_imm_32_for_pc` in 32: JALR target before bit-0 clear.
- `me_alu_out` in 32: ALU result, used as the memory address.
- `me_rs2_data` in 32: store data.
- `me_rd_addr` in 5: destination register.
- `ram_req` out 1: access request.
- `ram_we` out 1: 1 for store, 0 for load.
- `ram_addr` out 32: word-aligned address, `{me_alu_out[31:2],2'b00}`.
- `ram_be` out 4: byte enables.
- `ram_wdata` out 32: lane-replicated store data.
- `ram_ready` in 1: completes the access in the same cycle.
- `ram_rdata` in 32: load word, valid while `ram_ready`.
- `stall` out 1: ME cannot retire this cycle.
- `redirect_valid` out 1: one-cycle pulse requesting a PC redirect.
- `redirect_pc` out 32: redirect target.
- `misalign` out 1: one-cycle pulse on a misaligned access.
- `bus_error` out 1: one-cycle pulse on access timeout.
- `wb_write_reg_enable` out 1: registered register-file write enable.
- `wb_rd_addr` out 5: registered destination register.
- `wb_data` out 32: registered writeback data.

## Operation
- Access present when `me_write_ram_flag!=0` or `me_read_ram_flag` is in 1..5. If both are nonzero, the store wins.
- Misaligned when a halfword access has `addr[0]=1`, or a word access has `addr[1:0]!=0`.
  - No request is issued.
  - `misalign` pulses.
  - The ME/WB write is suppressed (`wb_write_reg_enable<=0`).
  - The instruction retires in one cycle.
- FSM states IDLE and WAIT.
  - IDLE: for an aligned access, `ram_req=1` combinationally. If `ram_ready` is high, the access completes this cycle; otherwise go to WAIT with `stall=1`.
  - WAIT: `ram_req=1` with identical addr/be/wdata/we. On `ram_ready`, go to IDLE and complete.
  - WAIT: the timeout counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES−1 without `ram_ready`: `bus_error` pulses, the write is suppressed, and the FSM goes to IDLE.
  - `stall = ram_req & ~ram_ready & ~timeout_fire`.
- Byte enables: SB gives `4'b0001<<addr[1:0]`; SH gives `4'b0011<<addr[1:0]`; SW gives `4'b1111`.
- `ram_wdata`: SB gives `{4{rs2[7:0]}}`; SH gives `{2{rs2[15:0]}}`; SW gives rs2.
- Load extract:
  - Select the byte at `rdata[8*addr[1:0]+:8]`, or the halfword at `rdata[16*addr[1]+:16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- ME/WB register updates only on cycles with `stall=0`. During a stall, `wb_write_reg_enable<=0` and a bubble is inserted.
- `wb_data` is the extended load when `me_wb_aluOut_or_memOut=1`, else `me_alu_out`.
- A store writes no register, regardless of `me_write_reg_enable`.
- Redirect is evaluated only when `stall=0`. Branches never access memory, so the redirect is produced in a single cycle.
  - cond 1 with `me_branch_enable` gives `me_pc_add_imm_32`.
  - cond 2 gives `me_pc_add_imm_32`.
  - cond 3 gives `me_rs1_data_add_imm_32_for_pc & ~1`.
  - cond 0 gives no redirect; `redirect_pc` holds its last value.

## Timing
- Reset values:
  - FSM in IDLE, counter 0.
  - `wb_write_reg_enable=0`, `wb_rd_addr=0`, `wb_data=0`.
  - Combinational outputs are 0 because inputs are ignored while `rst`.
  - `redirect_pc=0`.
- Zero-wait access: result appears on the `wb_*` outputs one `clk` edge after the ME cycle.
- N-wait access: `stall` is high for N cycles and `wb_*` updates on the edge after `ram_ready`.
- `rst` asserted mid-WAIT: the FSM returns to IDLE immediately, `ram_req` drops and no writeback occurs.
- `ram_ready` on the same cycle as the timeout boundary: ready wins; completion is normal and there is no `bus_error`.
- `ram_ready` asserted in IDLE with no request is ignored.
- Upstream must hold all `me_*` inputs stable while `stall=1`.

## Test plan
- LW at `0x100`, ready in the same cycle with `rdata=0xDEADBEEF` → no stall; next edge gives `wb_data=0xDEADBEEF`, `wb_write_reg_enable=1`.
- LB at `0x103`, ready after 3 wait cycles, `rdata=0x80FFFFFF` → `stall` high for 3 cycles with constant `ram_addr=0x100`; `wb_data=0xFFFFFF80`. LBU on the same data → `0x00000080`.
- SH at `0x102`, `rs2=0x1234ABCD` → `ram_we=1`, `ram_be=1100`, `ram_wdata=0xABCDABCD`, `wb_write_reg_enable=0`.
- LW at `0x101` → `misalign` pulse, `ram_req=0`, no stall, no register write.
- Load whose ready never arrives with TIMEOUT_CYCLES=16 → stall for 15 cycles, then `bus_error` pulse and no writeback. Repeat with `rst` asserted in cycle 5 → immediate IDLE, all outputs 0.
- JALR with `rs1+imm=0x2001` → `redirect_valid` pulse with `redirect_pc=0x2000`. A branch with `me_branch_enable=0` → no pulse.
